lms_anc_seq: RTL and testbench

Sequential, parametrised adaptive noise canceller. It cancels the noise component of a primary input using a correlated reference input through an N-tap adaptive FIR, and adapts the coefficients by LMS. A single time-multiplexed multiplier replaces the N parallel multipliers of the earlier datapath. Adds a valid/ready handshake on both sides, a selectable adaptation mode, a runtime power-of-two step size, saturating arithmetic and a synchronous coefficient clear.

---
 rtl/lms_anc_seq_pkg.sv | 36 +++
 rtl/lms_anc_seq_if.sv | 26 ++
 rtl/lms_anc_seq_mac.sv | 43 ++++
 rtl/lms_anc_seq.sv | 172 +++++++++++++++++
 tb/tb_lms_anc_seq.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lms_anc_seq_pkg.sv
// Shared types and helpers for the sequential LMS noise canceller.
//   anc_mode_e  : latched adaptation mode (plain LMS, sign-error LMS, frozen)
//   anc_state_e : sequencer states
//   saturate()  : clamps a wide signed value to a signed W-bit range
package anc_pkg;

  typedef enum logic [1:0] {
    MODE_LMS    = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_FROZEN = 2'b10
  } anc_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILTER = 3'd1,
    ERROR  = 3'd2,
    UPDATE = 3'd3,
    OUT    = 3'd4
  } anc_state_e;

  // Working width for saturate(); wide enough for every intermediate sum in
  // the datapath at any legal parameter combination.
  localparam int SAT_W = 96;

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/lms_anc_seq_if.sv
// Sample-in / result-out handshake bundle of the noise canceller.
//   in_valid/in_ready   : sample pair (d_in primary, ref_in noise reference)
//   out_valid/out_ready : result pair (e_out cleaned signal, y_out noise estimate)
// master drives samples and consumes results; slave is the canceller.
interface lms_anc_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] d_in;
  logic signed [DATA_WIDTH-1:0] ref_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] e_out;
  logic signed [DATA_WIDTH-1:0] y_out;

  modport master (
    output in_valid, d_in, ref_in, out_ready,
    input  in_ready, out_valid, e_out, y_out
  );

  modport slave (
    input  in_valid, d_in, ref_in, out_ready,
    output in_ready, out_valid, e_out, y_out
  );
endinterface

// File: rtl/lms_anc_seq_mac.sv
// Shared signed multiplier of the noise canceller.
//   upd      : 0 = filter operands (w_k * x_k), 1 = update operands (e_k * x_k)
//   w_k, x_k : current tap weight and delay-line sample
//   e_k      : adaptation error (already sign-mapped in sign-error mode)
//   mu_shift : step size exponent, added to the fixed Q-format realignment
//   prod     : full-precision product (accumulated while filtering)
//   w_new    : saturated updated weight w_k + (prod >>> shift)
module anc_mac
  import anc_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int COEF_WIDTH = 18,
  localparam int MW = (COEF_WIDTH > DATA_WIDTH) ? COEF_WIDTH : DATA_WIDTH,
  localparam int PW = MW + DATA_WIDTH
) (
  input  logic                         upd,
  input  logic signed [COEF_WIDTH-1:0] w_k,
  input  logic signed [DATA_WIDTH-1:0] e_k,
  input  logic signed [DATA_WIDTH-1:0] x_k,
  input  logic [3:0]                   mu_shift,
  output logic signed [PW-1:0]         prod,
  output logic signed [COEF_WIDTH-1:0] w_new
);
  // e*x is Q2.(2*DATA_WIDTH-2); shifting by this base lands it on the weight's
  // Q1.(COEF_WIDTH-1) grid before the step-size shift is applied.
  localparam int SHIFT_BASE = 2*DATA_WIDTH - 1 - COEF_WIDTH;

  logic signed [MW-1:0]    op_a;
  logic [6:0]              sh;
  logic signed [PW-1:0]    shifted;
  logic signed [PW:0]      sum;
  logic signed [SAT_W-1:0] w_full;

  always_comb begin
    op_a    = upd ? MW'(e_k) : MW'(w_k);
    prod    = PW'(op_a) * PW'(x_k);
    sh      = 7'(SHIFT_BASE) + 7'(mu_shift);
    shifted = prod >>> sh;
    sum     = (PW+1)'(w_k) + (PW+1)'(shifted);
    w_full  = saturate(SAT_W'(sum), COEF_WIDTH);
    w_new   = w_full[COEF_WIDTH-1:0];
  end
endmodule

// File: rtl/lms_anc_seq.sv
// Sequential adaptive noise canceller: N-tap FIR on the reference input with
// one time-multiplexed multiplier, LMS / sign-error LMS / frozen adaptation.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous zeroing of weights and delay line, aborts a sample
//   mode       : 00 LMS, 01 sign-error LMS, 1x frozen (latched per sample)
//   mu_shift   : step size 2^-mu_shift (latched per sample)
//   bus        : sample/result handshake (see lms_anc_seq_if)
module lms_anc_seq
  import anc_pkg::*;
#(
  parameter int N_TAPS     = 16,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 18,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(N_TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [1:0]    mode,
  input  logic [3:0]    mu_shift,
  lms_anc_seq_if.slave  bus
);
  localparam int IW = $clog2(N_TAPS);
  localparam int MW = (COEF_WIDTH > DATA_WIDTH) ? COEF_WIDTH : DATA_WIDTH;
  localparam int PW = MW + DATA_WIDTH;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_FILTER = FILTER;
  localparam logic [2:0] S_ERROR  = ERROR;
  localparam logic [2:0] S_UPDATE = UPDATE;
  localparam logic [2:0] S_OUT    = OUT;

  localparam logic signed [DATA_WIDTH-1:0] E_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [2:0]                   state;
  logic [IW-1:0]                idx;
  logic signed [DATA_WIDTH-1:0] x [N_TAPS];
  logic signed [COEF_WIDTH-1:0] w [N_TAPS];
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] d_lat;
  anc_mode_e                    mode_lat;
  logic [3:0]                   mu_lat;
  logic signed [DATA_WIDTH-1:0] e_r;
  logic signed [DATA_WIDTH-1:0] y_r;
  logic                         out_valid_r;

  logic                         last_tap;
  logic signed [ACC_WIDTH-1:0]  acc_sh;
  logic signed [SAT_W-1:0]      y_full;
  logic signed [SAT_W-1:0]      e_full;
  logic signed [DATA_WIDTH-1:0] y_n;
  logic signed [DATA_WIDTH-1:0] e_n;
  logic signed [DATA_WIDTH-1:0] e_sel;
  logic signed [PW-1:0]         prod;
  logic signed [COEF_WIDTH-1:0] w_new;

  assign last_tap      = (idx == IW'(N_TAPS - 1));
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.e_out     = e_r;
  assign bus.y_out     = y_r;

  // Output/error arithmetic (used in ERROR) and error operand for the update.
  always_comb begin
    acc_sh = acc >>> (COEF_WIDTH - 1);
    y_full = saturate(SAT_W'(acc_sh), DATA_WIDTH);
    y_n    = y_full[DATA_WIDTH-1:0];
    e_full = saturate(SAT_W'(d_lat) - SAT_W'(y_n), DATA_WIDTH);
    e_n    = e_full[DATA_WIDTH-1:0];
    e_sel  = e_r;
    if (mode_lat == MODE_SIGN) begin
      if (e_r == '0)              e_sel = '0;
      else if (e_r[DATA_WIDTH-1]) e_sel = -E_MAX;
      else                        e_sel = E_MAX;
    end
  end

  anc_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_mac (
    .upd      (state == S_UPDATE),
    .w_k      (w[idx]),
    .e_k      (e_sel),
    .x_k      (x[idx]),
    .mu_shift (mu_lat),
    .prod     (prod),
    .w_new    (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      acc         <= '0;
      d_lat       <= '0;
      mode_lat    <= MODE_LMS;
      mu_lat      <= '0;
      e_r         <= '0;
      y_r         <= '0;
      out_valid_r <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        x[k] <= '0;
        w[k] <= '0;
      end
    end else if (clear) begin
      state       <= S_IDLE;
      idx         <= '0;
      out_valid_r <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        x[k] <= '0;
        w[k] <= '0;
      end
    end else begin
      case (state)
        // Accept: shift reference into the delay line, latch sample controls.
        S_IDLE: begin
          if (bus.in_valid) begin
            x[0] <= bus.ref_in;
            for (int k = 1; k < N_TAPS; k++) x[k] <= x[k-1];
            d_lat    <= bus.d_in;
            mode_lat <= mode[1] ? MODE_FROZEN : (mode[0] ? MODE_SIGN : MODE_LMS);
            mu_lat   <= mu_shift;
            acc      <= '0;
            idx      <= '0;
            state    <= S_FILTER;
          end
        end
        // One MAC per tap at full accumulator precision.
        S_FILTER: begin
          acc <= acc + ACC_WIDTH'(prod);
          if (last_tap) begin
            idx   <= '0;
            state <= S_ERROR;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        // Register the noise estimate and error; frozen mode skips adaptation.
        S_ERROR: begin
          y_r <= y_n;
          e_r <= e_n;
          if (mode_lat == MODE_FROZEN) begin
            state       <= S_OUT;
            out_valid_r <= 1'b1;
          end else begin
            state <= S_UPDATE;
          end
        end
        // One weight update per tap through the same multiplier.
        S_UPDATE: begin
          w[idx] <= w_new;
          if (last_tap) begin
            idx         <= '0;
            state       <= S_OUT;
            out_valid_r <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        // Hold results until the consumer takes them.
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lms_anc_seq.sv
module tb_lms_anc_seq;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 16;

  typedef struct {
    int pre_clear;
    int mode;
    int mu;
    int d;
    int r;
    int exp_e;
    int exp_y;
  } vec_t;

  typedef struct {
    logic signed [DW-1:0] e;
    logic signed [DW-1:0] y;
    int                   lat;
  } exp_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       clear    = 1'b0;
  logic [1:0] mode     = 2'b00;
  logic [3:0] mu_shift = 4'd0;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sbq[$];
  vec_t   tbl[12];
  longint mw[N];
  longint mx[N];

  always #5 clk = ~clk;

  lms_anc_seq_if #(.DATA_WIDTH(DW)) bus();

  lms_anc_seq #(
    .N_TAPS     (N),
    .DATA_WIDTH (DW),
    .COEF_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .mode     (mode),
    .mu_shift (mu_shift),
    .bus      (bus)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mw[k] = 0;
      mx[k] = 0;
    end
  endtask

  // Reference behaviour of one sample for N=4, DW=CW=16.
  task automatic model_step(input longint d, input longint r, input int m, input int mu,
                            output longint e, output longint y);
    longint acc;
    longint ep;
    acc = 0;
    for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = r;
    for (int k = 0; k < N; k++) acc += mw[k] * mx[k];
    y = sat16(acc >>> 15);
    e = sat16(d - y);
    if (m == 1) ep = (e > 0) ? 32767 : ((e < 0) ? -32767 : 0);
    else        ep = e;
    if (m < 2)
      for (int k = 0; k < N; k++) mw[k] = sat16(mw[k] + ((ep * mx[k]) >>> (15 + mu)));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  // Drives one sample; returns #1 after the accepting edge.
  task automatic send(input int d, input int r, input int m, input int mu, input bit push,
                      input int exp_e, input int exp_y);
    int   guard;
    exp_t ex;
    guard = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_wait: got %b, expected 1", bus.in_ready);
    end
    bus.d_in     = DW'(d);
    bus.ref_in   = DW'(r);
    mode         = 2'(m);
    mu_shift     = 4'(mu);
    bus.in_valid = 1'b1;
    if (push) begin
      ex.e   = DW'(exp_e);
      ex.y   = DW'(exp_y);
      ex.lat = (m >= 2) ? N + 1 : 2 * N + 1;
      sbq.push_back(ex);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Changing controls mid-sample must not matter.
    mode     = 2'(m) ^ 2'b10;
    mu_shift = 4'(mu) ^ 4'hF;
  endtask

  task automatic collect(input string name);
    int   n;
    exp_t ex;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.out_valid !== 1'b1 && n < 100);
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_queue: got 0 entries, expected 1", name);
    end else begin
      ex = sbq.pop_front();
      chk({name, "_lat"}, n, ex.lat);
      chk({name, "_e"}, bus.e_out, ex.e);
      chk({name, "_y"}, bus.y_out, ex.y);
    end
    if (bus.out_ready === 1'b1) begin
      @(posedge clk);
      #1;
      chk({name, "_in_ready"}, bus.in_ready, 1);
      chk({name, "_ov_drop"}, bus.out_valid, 0);
    end
  endtask

  task automatic run(input int d, input int r, input int m, input int mu,
                     input int exp_e, input int exp_y, input string name);
    send(d, r, m, mu, 1'b1, exp_e, exp_y);
    collect(name);
  endtask

  initial begin
    longint me, my;

    tbl[0]  = '{1, 2, 0,   1000,   500,   1000,     0};
    tbl[1]  = '{1, 0, 0,  16384, 16384,  16384,     0};
    tbl[2]  = '{0, 0, 0,      0, 16384,  -4096,  4096};
    tbl[3]  = '{0, 2, 0,      0,     0,   1024, -1024};
    tbl[4]  = '{0, 2, 0,      0, 16384,  -3072,  3072};
    tbl[5]  = '{1, 1, 0,  16384, 16384,  16384,     0};
    tbl[6]  = '{0, 2, 0,      0, 16384,  -8191,  8191};
    tbl[7]  = '{1, 0, 2,  16384, 16384,  16384,     0};
    tbl[8]  = '{0, 2, 0,      0, 16384,  -1024,  1024};
    tbl[9]  = '{0, 3, 0,      5,     0,      5,     0};
    tbl[10] = '{1, 1, 0, -16384, 16384, -16384,     0};
    tbl[11] = '{0, 2, 0,      0, 16384,   8192, -8192};

    bus.in_valid  = 1'b0;
    bus.d_in      = '0;
    bus.ref_in    = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_e", bus.e_out, 0);
    chk("reset_y", bus.y_out, 0);
    chk("reset_ov", bus.out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_ov_after", bus.out_valid, 0);

    // Table of hand-derived vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].pre_clear != 0) do_clear();
      run(tbl[i].d, tbl[i].r, tbl[i].mode, tbl[i].mu, tbl[i].exp_e, tbl[i].exp_y,
          $sformatf("row%0d", i));
    end

    // Saturating training run, then error saturation in both directions
    do_clear();
    for (int i = 0; i < 8; i++) begin
      model_step(32767, 32767, 0, 0, me, my);
      run(32767, 32767, 0, 0, int'(me), int'(my), $sformatf("sat%0d", i));
    end
    model_step(32767, -32768, 2, 0, me, my);
    run(32767, -32768, 2, 0, int'(me), int'(my), "sat_hi");
    model_step(-32768, 32767, 2, 0, me, my);
    run(-32768, 32767, 2, 0, int'(me), int'(my), "sat_lo");

    // Backpressure
    do_clear();
    run(16384, 16384, 0, 0, 16384, 0, "bp_train");
    bus.out_ready = 1'b0;
    send(4321, 0, 2, 0, 1'b1, 4321, 0);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.d_in     = 16'sd777;
      bus.ref_in   = 16'sd9999;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_e%0d", i), bus.e_out, 4321);
      chk($sformatf("bp_hold_y%0d", i), bus.y_out, 0);
      chk($sformatf("bp_in_ready%0d", i), bus.in_ready, 0);
      chk($sformatf("bp_ov%0d", i), bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_release_ov", bus.out_valid, 0);
    run(0, 0, 2, 0, 0, 0, "bp_after");

    // Clear during UPDATE, with a competing in_valid
    send(16384, 16384, 0, 0, 1'b0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.d_in     = 16'sd55;
    bus.ref_in   = 16'sd66;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_in_ready", bus.in_ready, 1);
    chk("clr_ov", bus.out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("clr_no_output", bus.out_valid, 0);
    run(1234, 1000, 2, 0, 1234, 0, "clr_frozen");

    // Asynchronous reset in the middle of FILTER
    run(16384, 16384, 0, 0, 16384, 0, "pre_rst");
    send(100, 200, 0, 0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_e", bus.e_out, 0);
    chk("rst_mid_y", bus.y_out, 0);
    chk("rst_mid_ov", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    chk("rst_mid_ov_after", bus.out_valid, 0);
    run(-77, 300, 2, 0, -77, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
